char_writer: RTL
================

// Module: char_writer
// PURPOSE
//  Write-side controller for the 80x25 character buffer RAM. Accepts a byte stream
//  (valid/ready) from the terminal input path, keeps the cursor, writes printable
//  characters, and runs multi-cycle scroll/clear sequences through the RAM's
//  read and write ports. The video path reads the RAM on its own port; no arbitration here.
// PARAMETERS
//  COLS       80     characters per row
//  ROWS       25     rows per screen
//  BUF_SIZE   2000   RAM depth, must equal COLS*ROWS
//  ADDR_BITS  11     RAM address width
//  BLANK      8'h20  fill byte for scroll/clear
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  reset_n    in   1          asynchronous, active-low reset
//  in_data    in   8          input byte
//  in_valid   in   1          in_data valid
//  in_ready   out  1          byte accepted when in_valid&in_ready; =1 only in IDLE
//  waddr      out  ADDR_BITS  RAM write address (registered)
//  wdata      out  8          RAM write data (registered)
//  write_en   out  1          RAM write strobe (registered)
//  raddr      out  ADDR_BITS  RAM read address (registered)
//  read_en    out  1          RAM read strobe (registered)
//  rdata      in   8          RAM read data, valid 1 cycle after read_en
//  cursor_x   out  7          cursor column 0..COLS-1
//  cursor_y   out  5          cursor row 0..ROWS-1
// BEHAVIOUR
//  Reset (async): state IDLE, cursor (0,0), write_en=read_en=0, waddr=raddr=0, wdata=0.
//  States: IDLE, SCROLL, BLANKROW, CLEAR. in_ready = (state==IDLE); bytes never dropped.
//  IDLE, byte accepted at cycle t; effects (write strobe, cursor) visible at t+1:
//   0x20-0x7E: write_en=1, waddr=y*COLS+x, wdata=byte; x=x+1, saturating at COLS-1
//              (no autowrap; next char overwrites last column). Back-to-back OK.
//   0x0D CR: x=0.   0x08 BS: x=x-1 if x>0, else no change.
//   0x0A LF: if y<ROWS-1, y=y+1; else enter SCROLL, cursor unchanged.
//   0x0C FF: enter CLEAR.   Any other byte: consumed, no effect.
//  SCROLL (N=(ROWS-1)*COLS): cycle 0 read addr COLS; cycle k=1..N write rdata to
//   addr k-1 and, if k<N, read addr COLS+k. Then BLANKROW.
//  BLANKROW: COLS cycles writing BLANK to N..BUF_SIZE-1, then IDLE.
//   LF-at-bottom busy time = 1+N+COLS = 2001 cycles at defaults.
//  CLEAR: BUF_SIZE cycles writing BLANK to 0..BUF_SIZE-1, cursor (0,0) on entry, then IDLE.
//  Strobes low in every cycle not listed above; read_en never asserted outside SCROLL.
//  Address arithmetic: y*COLS+x in ADDR_BITS, no overflow for legal cursor.
//  Reset mid-sequence: abort immediately; RAM left partially updated; strobes low.
//  in_valid while busy: not accepted; source holds the byte until IDLE.
// TESTING
//  1. Reset, send 'A','B' back-to-back -> writes 0x41@0, 0x42@1; cursor (2,0).
//  2. 85 printables on row 0 -> chars 80..85 all written at addr 79; cursor_x=79.
//  3. CR, BS at x=0, LF x3 -> cursor (0,3); no write strobes; in_ready stays 1.
//  4. Fill RAM with addr-derived pattern, cursor y=24, LF -> in_ready low 2001 cycles;
//     addr a<1920 holds old[a+80]; 1920..1999 = 0x20; cursor y stays 24.
//  5. FF -> 2000 writes of 0x20, cursor (0,0), in_ready low exactly 2000 cycles.
//  6. Assert reset_n=0 at scroll cycle 500 -> strobes drop, state IDLE, cursor (0,0).

Source files
------------

// File: rtl/char_writer.sv
// Write-side controller for the character buffer RAM: tracks the cursor, writes
// printable bytes and streams scroll/clear sequences through the RAM ports.
module char_writer #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 25,
    parameter int         BUF_SIZE  = 2000,
    parameter int         ADDR_BITS = 11,
    parameter logic [7:0] BLANK     = 8'h20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ADDR_BITS-1:0] waddr,
    output logic [7:0]           wdata,
    output logic                 write_en,
    output logic [ADDR_BITS-1:0] raddr,
    output logic                 read_en,
    input  logic [7:0]           rdata,
    output logic [6:0]           cursor_x,
    output logic [4:0]           cursor_y
);
    typedef logic [ADDR_BITS-1:0] addr_t;
    typedef enum logic [1:0] {IDLE, SCROLL, BLANKROW, CLEAR} state_t;

    localparam addr_t      A_ONE       = addr_t'(1);
    localparam addr_t      A_COLS      = addr_t'(COLS);
    localparam addr_t      A_COLS_M1   = addr_t'(COLS - 1);
    localparam addr_t      A_SCROLL    = addr_t'((ROWS - 1) * COLS);
    localparam addr_t      A_SCROLL_M1 = addr_t'((ROWS - 1) * COLS - 1);
    localparam addr_t      A_LAST      = addr_t'(BUF_SIZE - 1);
    localparam logic [6:0] X_MAX       = 7'(COLS - 1);
    localparam logic [4:0] Y_MAX       = 5'(ROWS - 1);

    state_t     state_q, state_d;
    addr_t      cnt_q, cnt_d;
    logic [6:0] x_q, x_d;
    logic [4:0] y_q, y_d;
    addr_t      waddr_q, waddr_d;
    addr_t      raddr_q, raddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       write_en_q, write_en_d;
    logic       read_en_q, read_en_d;
    addr_t      cur_addr;

    assign cur_addr = addr_t'(y_q) * A_COLS + addr_t'(x_q);

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        wdata_d    = wdata_q;
        write_en_d = 1'b0;
        read_en_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        write_en_d = 1'b1;
                        waddr_d    = cur_addr;
                        wdata_d    = in_data;
                        if (x_q != X_MAX) x_d = x_q + 7'd1;
                    end else begin
                        case (in_data)
                            8'h0D: x_d = '0;
                            8'h08: begin
                                if (x_q != '0) x_d = x_q - 7'd1;
                            end
                            8'h0A: begin
                                if (y_q != Y_MAX) begin
                                    y_d = y_q + 5'd1;
                                end else begin
                                    state_d   = SCROLL;
                                    cnt_d     = '0;
                                    read_en_d = 1'b1;
                                    raddr_d   = A_COLS;
                                end
                            end
                            8'h0C: begin
                                state_d    = CLEAR;
                                cnt_d      = '0;
                                x_d        = '0;
                                y_d        = '0;
                                write_en_d = 1'b1;
                                waddr_d    = '0;
                                wdata_d    = BLANK;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            // Count k: rdata holds the row-below byte read in k-1, copied up one row.
            SCROLL: begin
                if (cnt_q != '0) begin
                    write_en_d = 1'b1;
                    waddr_d    = cnt_q - A_ONE;
                    wdata_d    = rdata;
                end
                if (cnt_q < A_SCROLL_M1) begin
                    read_en_d = 1'b1;
                    raddr_d   = A_COLS + cnt_q + A_ONE;
                end
                if (cnt_q == A_SCROLL) begin
                    state_d = BLANKROW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + A_ONE;
                end
            end
            BLANKROW: begin
                write_en_d = 1'b1;
                waddr_d    = A_SCROLL + cnt_q;
                wdata_d    = BLANK;
                if (cnt_q == A_COLS_M1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + A_ONE;
                end
            end
            CLEAR: begin
                if (cnt_q == A_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d      = cnt_q + A_ONE;
                    write_en_d = 1'b1;
                    waddr_d    = cnt_q + A_ONE;
                    wdata_d    = BLANK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            wdata_q    <= '0;
            write_en_q <= 1'b0;
            read_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            wdata_q    <= wdata_d;
            write_en_q <= write_en_d;
            read_en_q  <= read_en_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign waddr    = waddr_q;
    assign raddr    = raddr_q;
    assign wdata    = wdata_q;
    assign write_en = write_en_q;
    assign read_en  = read_en_q;
    assign cursor_x = x_q;
    assign cursor_y = y_q;
endmodule
